// File: rtl/fb_div_pkg.sv
// Shared definitions for the PLL feedback-divider pulse-swallow controller.
// Holds the default counter width, the minimum legal P, the reset-time P/S
// program values and the controller FSM state encoding.
package fb_div_pkg;

   localparam int CNT_WIDTH     = 6;
   localparam int DIV_P_MIN     = 2;
   localparam int DIV_P_DEFAULT = 32;
   localparam int DIV_S_DEFAULT = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/fb_div_cfg_sanitize.sv
// Combinational clamp of the programmed divider values.
//   divP, divS : raw programmed P / S
//   pNext      : P clamped to at least DIV_P_MIN
//   sNext      : S clamped to at most the clamped P
//   err        : high when either value had to be clamped
// S is compared against the already-clamped P, so divS==pNext stays legal
// (whole period swallowed, N = 3P).
module fb_div_cfg_sanitize
   import fb_div_pkg::*;
#(
   parameter int CNT_WIDTH = fb_div_pkg::CNT_WIDTH
) (
   input  logic [CNT_WIDTH-1:0] divP,
   input  logic [CNT_WIDTH-1:0] divS,
   output logic [CNT_WIDTH-1:0] pNext,
   output logic [CNT_WIDTH-1:0] sNext,
   output logic                 err
);

   localparam logic [CNT_WIDTH-1:0] P_MIN = CNT_WIDTH'(DIV_P_MIN);

   logic err_p;
   logic err_s;

   always_comb begin
      pNext = divP;
      err_p = 1'b0;
      if (divP < P_MIN) begin
         pNext = P_MIN;
         err_p = 1'b1;
      end

      sNext = divS;
      err_s = 1'b0;
      if (divS > pNext) begin
         sNext = pNext;
         err_s = 1'b1;
      end

      err = err_p | err_s;
   end

endmodule

// File: rtl/fb_div_swallow_ctrl.sv
// Pulse-swallow controller for the PLL feedback divider, clocked by the 2/3
// prescaler output. Each output period spans P prescaler cycles; skip is high
// for the first S of them, giving N = 2*P + S at the prescaler input.
//   clk1G28     : prescaler output clock (only clock)
//   rst         : asynchronous active-high reset
//   enable      : run request, honoured only at a period boundary
//   divP, divS  : programmed P and S, latched at a period boundary
//   skip        : prescaler divide-by-3 request for this cycle
//   clkOut      : divided feedback clock, high for floor(P/2) cycles
//   periodStart : one-cycle strobe on the first cycle of each period
//   cfgErr      : sticky, set when a latched divP/divS had to be clamped
// All outputs are flops decoded from next-state values, so each output
// cycle lines up with the counter value held in that same cycle.
module fb_div_swallow_ctrl
   import fb_div_pkg::*;
#(
   parameter int CNT_WIDTH     = fb_div_pkg::CNT_WIDTH,
   parameter int DIV_P_DEFAULT = fb_div_pkg::DIV_P_DEFAULT,
   parameter int DIV_S_DEFAULT = fb_div_pkg::DIV_S_DEFAULT
) (
   input  logic                 clk1G28,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] divP,
   input  logic [CNT_WIDTH-1:0] divS,
   output logic                 skip,
   output logic                 clkOut,
   output logic                 periodStart,
   output logic                 cfgErr
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [CNT_WIDTH-1:0] p_lat, p_lat_n;
   logic [CNT_WIDTH-1:0] s_lat, s_lat_n;
   logic                 skip_n, clk_out_n, period_start_n, cfg_err_n;

   logic [CNT_WIDTH-1:0] p_san, s_san;
   logic                 san_err;
   logic                 latch;

   fb_div_cfg_sanitize #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_sanitize (
      .divP  (divP),
      .divS  (divS),
      .pNext (p_san),
      .sNext (s_san),
      .err   (san_err)
   );

   always_ff @(posedge clk1G28 or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         p_lat       <= CNT_WIDTH'(DIV_P_DEFAULT);
         s_lat       <= CNT_WIDTH'(DIV_S_DEFAULT);
         skip        <= 1'b0;
         clkOut      <= 1'b0;
         periodStart <= 1'b0;
         cfgErr      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         p_lat       <= p_lat_n;
         s_lat       <= s_lat_n;
         skip        <= skip_n;
         clkOut      <= clk_out_n;
         periodStart <= period_start_n;
         cfgErr      <= cfg_err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      latch   = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (enable) begin
               state_n = RUN;
               latch   = 1'b1;
            end
         end
         RUN: begin
            // Terminal count: the period always completes before enable is
            // looked at, so there is never a runt output clock.
            if (cnt == p_lat - ONE) begin
               cnt_n = '0;
               if (enable) latch   = 1'b1;
               else        state_n = IDLE;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      p_lat_n = latch ? p_san : p_lat;
      s_lat_n = latch ? s_san : s_lat;

      period_start_n = latch;
      skip_n         = (state_n == RUN) && (cnt_n < s_lat_n);
      clk_out_n      = (state_n == RUN) && (cnt_n < (p_lat_n >> 1));
      cfg_err_n      = cfgErr | (latch & san_err);
   end

endmodule
